// File: rtl/pong_ball_engine.sv
// Ball physics and scoring for Pong: moves the ball once per frame tick, bounces it
// off walls and paddles, keeps score and sequences serve / point-hold / game-over.
module pong_ball_engine #(
  parameter int unsigned X_W         = 10,
  parameter int unsigned Y_W         = 10,
  parameter int unsigned FIELD_W     = 640,
  parameter int unsigned FIELD_H     = 480,
  parameter int unsigned BALL        = 8,
  parameter int unsigned PAD_H       = 64,
  parameter int unsigned PAD_X       = 16,
  parameter int unsigned SPEED       = 4,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               serve,
  input  logic [Y_W-1:0]     pad_l_y,
  input  logic [Y_W-1:0]     pad_r_y,
  output logic [X_W-1:0]     ball_x,
  output logic [Y_W-1:0]     ball_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               hit_l,
  output logic               hit_r,
  output logic               point_l,
  output logic               point_r,
  output logic [1:0]         state
);

  localparam int unsigned XE_W   = X_W + 1;
  localparam int unsigned YE_W   = Y_W + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [X_W-1:0]     CX      = X_W'((FIELD_W - BALL) / 2);
  localparam logic [Y_W-1:0]     CY      = Y_W'((FIELD_H - BALL) / 2);
  localparam logic [Y_W-1:0]     YMAX    = Y_W'(FIELD_H - BALL);
  localparam logic [X_W-1:0]     LX      = X_W'(PAD_X);
  localparam logic [X_W-1:0]     RX      = X_W'(FIELD_W - PAD_X - BALL);
  localparam logic [XE_W-1:0]    LX_E    = XE_W'(PAD_X);
  localparam logic [XE_W-1:0]    RX_E    = XE_W'(FIELD_W - PAD_X - BALL);
  localparam logic [XE_W-1:0]    SPD_X   = XE_W'(SPEED);
  localparam logic [YE_W-1:0]    SPD_Y   = YE_W'(SPEED);
  localparam logic [YE_W-1:0]    YMAX_E  = YE_W'(FIELD_H - BALL);
  localparam logic [YE_W-1:0]    BALL_E  = YE_W'(BALL);
  localparam logic [YE_W-1:0]    PADH_E  = YE_W'(PAD_H);
  localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD    = HOLD_W'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2,
    ST_OVER   = 2'd3
  } state_e;

  state_e             st_q, st_d;
  logic [X_W-1:0]     ball_x_q, ball_x_d;
  logic [Y_W-1:0]     ball_y_q, ball_y_d;
  logic               dir_x_q, dir_x_d;
  logic               dir_y_q, dir_y_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               hit_l_q, hit_l_d;
  logic               hit_r_q, hit_r_d;
  logic               point_l_q, point_l_d;
  logic               point_r_q, point_r_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic [XE_W-1:0]    x_e;
  logic [YE_W-1:0]    y_e, pl_e, pr_e;
  logic [Y_W-1:0]     y_mv;
  logic               dy_mv;
  logic               at_r, at_l, ovl_r, ovl_l;
  logic [SCORE_W-1:0] sl_inc, sr_inc;

  // Vertical step with wall reflection, and paddle-plane / overlap tests, one bit wide of overflow
  always_comb begin
    x_e    = {1'b0, ball_x_q};
    y_e    = {1'b0, ball_y_q};
    pl_e   = {1'b0, pad_l_y};
    pr_e   = {1'b0, pad_r_y};
    y_mv   = ball_y_q;
    dy_mv  = dir_y_q;
    if (dir_y_q) begin
      if (y_e + SPD_Y >= YMAX_E) begin
        y_mv  = YMAX;
        dy_mv = 1'b0;
      end else begin
        y_mv = Y_W'(y_e + SPD_Y);
      end
    end else begin
      if (y_e < SPD_Y) begin
        y_mv  = '0;
        dy_mv = 1'b1;
      end else begin
        y_mv = Y_W'(y_e - SPD_Y);
      end
    end
    at_r   = (x_e + SPD_X >= RX_E);
    at_l   = (x_e <= LX_E + SPD_X);
    ovl_r  = (y_e + BALL_E > pr_e) && (y_e < pr_e + PADH_E);
    ovl_l  = (y_e + BALL_E > pl_e) && (y_e < pl_e + PADH_E);
    sl_inc = score_l_q + SCORE_W'(1);
    sr_inc = score_r_q + SCORE_W'(1);
  end

  // Next-state and next-output logic
  always_comb begin
    st_d      = st_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    hold_d    = hold_q;
    hit_l_d   = 1'b0;
    hit_r_d   = 1'b0;
    point_l_d = 1'b0;
    point_r_d = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (serve) st_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (frame_tick) begin
          ball_y_d = y_mv;
          dir_y_d  = dy_mv;
          if (dir_x_q) begin
            if (!at_r) begin
              ball_x_d = X_W'(x_e + SPD_X);
            end else if (ovl_r) begin
              ball_x_d = RX;
              dir_x_d  = 1'b0;
              hit_r_d  = 1'b1;
            end else begin
              point_l_d = 1'b1;
              score_l_d = sl_inc;
              ball_x_d  = CX;
              ball_y_d  = CY;
              dir_y_d   = dir_y_q;
              dir_x_d   = 1'b1;
              st_d      = (sl_inc == WIN) ? ST_OVER : ST_SCORED;
              hold_d    = (sl_inc == WIN) ? '0 : HOLD;
            end
          end else begin
            if (!at_l) begin
              ball_x_d = X_W'(x_e - SPD_X);
            end else if (ovl_l) begin
              ball_x_d = LX;
              dir_x_d  = 1'b1;
              hit_l_d  = 1'b1;
            end else begin
              point_r_d = 1'b1;
              score_r_d = sr_inc;
              ball_x_d  = CX;
              ball_y_d  = CY;
              dir_y_d   = dir_y_q;
              dir_x_d   = 1'b0;
              st_d      = (sr_inc == WIN) ? ST_OVER : ST_SCORED;
              hold_d    = (sr_inc == WIN) ? '0 : HOLD;
            end
          end
        end
      end
      ST_SCORED: begin
        if (frame_tick) begin
          if (hold_q <= HOLD_W'(1)) begin
            hold_d = '0;
            st_d   = ST_PLAY;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (serve) begin
          score_l_d = '0;
          score_r_d = '0;
          ball_x_d  = CX;
          ball_y_d  = CY;
          dir_x_d   = 1'b1;
          dir_y_d   = 1'b1;
          st_d      = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      ball_x_q  <= CX;
      ball_y_q  <= CY;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      score_l_q <= '0;
      score_r_q <= '0;
      hold_q    <= '0;
      hit_l_q   <= 1'b0;
      hit_r_q   <= 1'b0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      hold_q    <= hold_d;
      hit_l_q   <= hit_l_d;
      hit_r_q   <= hit_r_d;
      point_l_q <= point_l_d;
      point_r_q <= point_r_d;
    end
  end

  assign ball_x  = ball_x_q;
  assign ball_y  = ball_y_q;
  assign dir_x   = dir_x_q;
  assign dir_y   = dir_y_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;
  assign hit_l   = hit_l_q;
  assign hit_r   = hit_r_q;
  assign point_l = point_l_q;
  assign point_r = point_r_q;
  assign state   = st_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Scoreboard bench for pong_ball_engine: directed game scenarios plus random play,
// with a behavioural integer model feeding an expectation queue drained by a monitor.
module tb_pong_ball_engine;

  localparam int FW = 640, FH = 480, BL = 8, PH = 64, PX = 16, SP = 4;
  localparam int WIN = 9, HOLD = 60;
  localparam int CX = (FW - BL) / 2, CY = (FH - BL) / 2;
  localparam int YMAX = FH - BL, LX = PX, RX = FW - PX - BL;

  logic       clk = 1'b0;
  logic       rst, frame_tick, serve;
  logic [9:0] pad_l_y, pad_r_y;
  logic [9:0] ball_x, ball_y;
  logic       dir_x, dir_y, hit_l, hit_r, point_l, point_r;
  logic [3:0] score_l, score_r;
  logic [1:0] state;

  pong_ball_engine dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .serve(serve),
    .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
    .score_l(score_l), .score_r(score_r),
    .hit_l(hit_l), .hit_r(hit_r), .point_l(point_l), .point_r(point_r),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bx, by, dx, dy, sl, sr, hl, hr, pl, pr, st;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // Behavioural game state (0 idle, 1 play, 2 scored, 3 over)
  int m_bx, m_by, m_dx, m_dy, m_sl, m_sr, m_st, m_hold;
  int m_hl, m_hr, m_pl, m_pr;

  function automatic void chk(string nm, int act, int expv);
    n_vec++;
    if (act != expv) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endfunction

  function automatic void concede(int new_dx, int keep_dy);
    m_bx = CX;
    m_by = CY;
    m_dx = new_dx;
    m_dy = keep_dy;
    if (m_sl == WIN || m_sr == WIN) begin
      m_st   = 3;
      m_hold = 0;
    end else begin
      m_st   = 2;
      m_hold = HOLD;
    end
  endfunction

  function automatic void model_step(bit r, bit t, bit s, int lp, int rp);
    int y0, dy0;
    m_hl = 0; m_hr = 0; m_pl = 0; m_pr = 0;
    if (r) begin
      m_bx = CX; m_by = CY; m_dx = 1; m_dy = 1;
      m_sl = 0; m_sr = 0; m_st = 0; m_hold = 0;
      return;
    end
    case (m_st)
      0: if (s) m_st = 1;
      1: if (t) begin
        y0  = m_by;
        dy0 = m_dy;
        if (dy0 == 1) begin
          if (y0 + SP >= YMAX) begin m_by = YMAX; m_dy = 0; end
          else m_by = y0 + SP;
        end else begin
          if (y0 < SP) begin m_by = 0; m_dy = 1; end
          else m_by = y0 - SP;
        end
        if (m_dx == 1) begin
          if (m_bx + SP < RX) m_bx = m_bx + SP;
          else if (y0 + BL > rp && y0 < rp + PH) begin m_bx = RX; m_dx = 0; m_hr = 1; end
          else begin m_pl = 1; m_sl++; concede(1, dy0); end
        end else begin
          if (m_bx > LX + SP) m_bx = m_bx - SP;
          else if (y0 + BL > lp && y0 < lp + PH) begin m_bx = LX; m_dx = 1; m_hl = 1; end
          else begin m_pr = 1; m_sr++; concede(0, dy0); end
        end
      end
      2: if (t) begin
        m_hold--;
        if (m_hold == 0) m_st = 1;
      end
      default: if (s) begin
        m_sl = 0; m_sr = 0; m_bx = CX; m_by = CY; m_dx = 1; m_dy = 1; m_st = 0;
      end
    endcase
  endfunction

  // One clock of stimulus: drive on the falling edge, record the expected post-edge outputs
  task automatic cyc(bit r, bit t, bit s);
    exp_t e;
    @(negedge clk);
    rst = r; frame_tick = t; serve = s;
    if (r) begin
      #1;
      chk("async_rst_ball_x", int'(ball_x), CX);
      chk("async_rst_state", int'(state), 0);
    end
    model_step(r, t, s, int'(pad_l_y), int'(pad_r_y));
    e.bx = m_bx; e.by = m_by; e.dx = m_dx; e.dy = m_dy; e.sl = m_sl; e.sr = m_sr;
    e.hl = m_hl; e.hr = m_hr; e.pl = m_pl; e.pr = m_pr; e.st = m_st;
    exp_q.push_back(e);
    @(posedge clk);
    #3;
  endtask

  function automatic logic [9:0] pick_pad();
    int p;
    if ($urandom_range(0, 2) == 0) return 10'($urandom_range(0, 1023));
    p = m_by - PH + int'($urandom_range(0, PH + BL));
    if (p < 0) p = 0;
    return 10'(p);
  endfunction

  // Monitor: every clock the DUT presents a full output set, compared against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ball_x", int'(ball_x), e.bx);
        chk("ball_y", int'(ball_y), e.by);
        chk("dir_x", int'(dir_x), e.dx);
        chk("dir_y", int'(dir_y), e.dy);
        chk("score_l", int'(score_l), e.sl);
        chk("score_r", int'(score_r), e.sr);
        chk("hit_l", int'(hit_l), e.hl);
        chk("hit_r", int'(hit_r), e.hr);
        chk("point_l", int'(point_l), e.pl);
        chk("point_r", int'(point_r), e.pr);
        chk("state", int'(state), e.st);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b0; frame_tick = 1'b0; serve = 1'b0;
    pad_l_y = '0; pad_r_y = 10'd380;

    // Reset values
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("reset_ball_y", int'(ball_y), 236);
    chk("reset_dirs", int'({dir_x, dir_y}), 3);

    // Serve, wall bounce at the bottom, then a right paddle hit
    cyc(0, 0, 1);
    for (int i = 0; i < 59; i++) cyc(0, 1, 0);
    chk("bottom_y", int'(ball_y), 472);
    chk("bottom_dir_y", int'(dir_y), 0);
    cyc(0, 1, 0);
    chk("tick60_y", int'(ball_y), 468);
    chk("tick60_x", int'(ball_x), 556);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0);
    chk("hit_r_pulse", int'(hit_r), 1);
    chk("hit_r_x", int'(ball_x), 616);
    chk("hit_r_dir_x", int'(dir_x), 0);
    chk("hit_r_score_r", int'(score_r), 0);
    cyc(0, 0, 0);
    chk("hit_r_one_cycle", int'(hit_r), 0);

    // Miss on the right: point to the left player, hold, then resume
    cyc(1, 0, 0);
    pad_r_y = '0;
    cyc(0, 0, 1);
    for (int i = 0; i < 75; i++) cyc(0, 1, 0);
    chk("miss_point_l", int'(point_l), 1);
    chk("miss_score_l", int'(score_l), 1);
    chk("miss_state", int'(state), 2);
    chk("miss_ball", int'({ball_x, ball_y}), (316 << 10) | 236);
    for (int i = 0; i < 59; i++) cyc(0, 1, 0);
    chk("hold_59_state", int'(state), 2);
    cyc(0, 1, 0);
    chk("hold_done_state", int'(state), 1);
    chk("hold_done_dir_x", int'(dir_x), 1);

    // Play to game over: left paddle tracks the ball, right paddle stays clear of it
    n = 0;
    while (m_st != 3 && n < 5000) begin
      pad_l_y = 10'(m_by);
      pad_r_y = (m_by < 240) ? 10'd400 : 10'd0;
      cyc(0, 1, 0);
      n++;
    end
    chk("over_state", int'(state), 3);
    chk("over_score_l", int'(score_l), 9);
    chk("over_score_r", int'(score_r), 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    chk("over_frozen", int'({ball_x, ball_y}), (316 << 10) | 236);
    cyc(0, 0, 1);
    chk("restart_state", int'(state), 0);
    chk("restart_scores", int'({score_l, score_r}), 0);

    // Mid-rally reset, then serve coinciding with a tick
    cyc(0, 0, 1);
    while (m_bx != 400) cyc(0, 1, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0);
    chk("post_rst_idle", int'(state), 0);
    chk("post_rst_x", int'(ball_x), 316);
    cyc(0, 1, 1);
    chk("serve_tick_state", int'(state), 1);
    chk("serve_tick_x", int'(ball_x), 316);
    cyc(0, 1, 0);
    chk("first_move_x", int'(ball_x), 320);

    // Random play
    for (int i = 0; i < 30000; i++) begin
      bit r, t, s;
      r = ($urandom_range(0, 3999) == 0);
      t = ($urandom_range(0, 3) != 0);
      if (m_st == 0 || m_st == 3) s = ($urandom_range(0, 7) == 0);
      else s = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) pad_l_y = pick_pad();
      if ($urandom_range(0, 3) == 0) pad_r_y = pick_pad();
      cyc(r, t, s);
    end

    cyc(0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
